// File: rtl/timer_preset_ctrl.sv
// Control stage for the six-digit BCD countdown timer: preset editor, load strobe, run enable.
// Define TIMER_PRESET_BLINK_EN to build the edit-digit blink generator; otherwise blank is tied low.
module timer_preset_ctrl #(
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter logic [23:0] PRESET_INIT = 24'h010000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        btn_sel,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_start,
  input  logic        btn_mode,
  input  logic        tmr_zero,
  output logic [23:0] preset,
  output logic        load,
  output logic        run_en,
  output logic [2:0]  edit_sel,
  output logic [5:0]  blank,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    EDIT    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t      r_state;
  logic [23:0] r_preset;
  logic        r_load;
  logic        r_runEn;
  logic [2:0]  r_editSel;

  state_t      w_nextState;
  logic        w_nextLoad;
  logic        w_nextRunEn;
  logic        w_editAllowed;
  logic [23:0] w_nextPreset;
  logic [2:0]  w_nextEditSel;
  logic [3:0]  w_selDigit;
  logic [3:0]  w_maxDigit;
  logic [3:0]  w_newDigit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= EDIT;
      r_preset  <= PRESET_INIT;
      r_load    <= 1'b0;
      r_runEn   <= 1'b0;
      r_editSel <= 3'd0;
    end else begin
      r_state   <= w_nextState;
      r_preset  <= w_nextPreset;
      r_load    <= w_nextLoad;
      r_runEn   <= w_nextRunEn;
      r_editSel <= w_nextEditSel;
    end
  end

  // A zero count in RUN takes precedence over a simultaneous pause request.
  always_comb begin
    w_nextState   = r_state;
    w_nextLoad    = 1'b0;
    w_nextRunEn   = 1'b0;
    w_editAllowed = 1'b0;
    case (r_state)
      EDIT: begin
        if (btn_start && (r_preset != 24'h0)) begin
          w_nextState = RUN;
          w_nextLoad  = 1'b1;
          w_nextRunEn = 1'b1;
        end else begin
          w_editAllowed = 1'b1;
        end
      end
      RUN: begin
        if (tmr_zero) begin
          w_nextState = EDIT;
        end else if (btn_start) begin
          w_nextState = PAUSE;
        end else begin
          w_nextRunEn = 1'b1;
        end
      end
      PAUSE: begin
        if (btn_start) begin
          w_nextState = RUN;
          w_nextRunEn = 1'b1;
        end else if (btn_mode) begin
          w_nextState = EDIT;
        end
      end
      default: begin
        w_nextState = EDIT;
      end
    endcase
  end

  // Tens-of-seconds and tens-of-minutes digits wrap at 5, the rest at 9.
  always_comb begin
    w_nextPreset  = r_preset;
    w_nextEditSel = r_editSel;
    w_selDigit    = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (r_editSel == 3'(i)) w_selDigit = r_preset[4*i +: 4];
    end
    w_maxDigit = ((r_editSel == 3'd1) || (r_editSel == 3'd3)) ? 4'd5 : 4'd9;
    w_newDigit = w_selDigit;
    if (btn_inc && !btn_dec) begin
      w_newDigit = (w_selDigit >= w_maxDigit) ? 4'd0 : w_selDigit + 4'd1;
    end else if (btn_dec && !btn_inc) begin
      w_newDigit = (w_selDigit == 4'd0) ? w_maxDigit : w_selDigit - 4'd1;
    end
    if (w_editAllowed) begin
      for (int i = 0; i < 6; i++) begin
        if (r_editSel == 3'(i)) w_nextPreset[4*i +: 4] = w_newDigit;
      end
      if (btn_sel) w_nextEditSel = (r_editSel == 3'd5) ? 3'd0 : r_editSel + 3'd1;
    end
  end

`ifdef TIMER_PRESET_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] r_blinkCnt;
  logic             r_blinkPhase;
  logic [CNT_W-1:0] w_nextBlinkCnt;
  logic             w_nextBlinkPhase;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else begin
      r_blinkCnt   <= w_nextBlinkCnt;
      r_blinkPhase <= w_nextBlinkPhase;
    end
  end

  // Any edit press restarts the blink with the digit visible.
  always_comb begin
    w_nextBlinkCnt   = r_blinkCnt + 1'b1;
    w_nextBlinkPhase = r_blinkPhase;
    if ((r_state == EDIT) && (btn_sel || btn_inc || btn_dec)) begin
      w_nextBlinkCnt   = '0;
      w_nextBlinkPhase = 1'b0;
    end else if (r_blinkCnt == CNT_W'(BLINK_DIV - 1)) begin
      w_nextBlinkCnt   = '0;
      w_nextBlinkPhase = ~r_blinkPhase;
    end
  end

  assign blank = ((r_state == EDIT) && r_blinkPhase) ? (6'b000001 << r_editSel) : 6'b0;
`else
  assign blank = 6'b0;
`endif

  assign preset   = r_preset;
  assign load     = r_load;
  assign run_en   = r_runEn;
  assign edit_sel = r_editSel;
  assign state    = r_state;

endmodule

// File: tb/tb_timer_preset_ctrl.sv
// Bench for timer_preset_ctrl: directed scenarios with literal expectations, then randomized
// button traffic compared every cycle against an integer-level behavioural model.
module tb_timer_preset_ctrl;

  localparam int unsigned BLINK_DIV   = 4;
  localparam logic [23:0] PRESET_INIT = 24'h010000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        btn_sel = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_mode = 1'b0;
  logic        tmr_zero = 1'b0;
  logic [23:0] preset;
  logic        load;
  logic        run_en;
  logic [2:0]  edit_sel;
  logic [5:0]  blank;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Model: state as 0=EDIT 1=RUN 2=PAUSE, digits as plain integers
  int mState;
  int mSel;
  int mDig[6];
  int mBlinkCnt;
  bit mLoad;
  bit mRun;
  bit mPhase;

  timer_preset_ctrl #(
    .BLINK_DIV  (BLINK_DIV),
    .PRESET_INIT(PRESET_INIT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .btn_sel  (btn_sel),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .btn_start(btn_start),
    .btn_mode (btn_mode),
    .tmr_zero (tmr_zero),
    .preset   (preset),
    .load     (load),
    .run_en   (run_en),
    .edit_sel (edit_sel),
    .blank    (blank),
    .state    (state)
  );

  always #5 CLK = ~CLK;

  function automatic int digitMax(int i);
    return ((i == 1) || (i == 3)) ? 5 : 9;
  endfunction

  function automatic logic [23:0] modelPreset();
    logic [23:0] p;
    p = 24'h0;
    for (int i = 0; i < 6; i++) p[4*i +: 4] = 4'(mDig[i]);
    return p;
  endfunction

  function automatic logic [5:0] modelBlank();
`ifdef TIMER_PRESET_BLINK_EN
    logic [5:0] b;
    b = 6'b0;
    if ((mState == 0) && mPhase) b[mSel] = 1'b1;
    return b;
`else
    return 6'b0;
`endif
  endfunction

  task automatic modelReset();
    mState    = 0;
    mSel      = 0;
    mLoad     = 1'b0;
    mRun      = 1'b0;
    mBlinkCnt = 0;
    mPhase    = 1'b0;
    for (int i = 0; i < 6; i++) mDig[i] = int'((PRESET_INIT >> (4*i)) & 24'hF);
  endtask

  always @(posedge CLK) begin : model
    int  oldState;
    bit  editOk;
    if (RST) begin
      modelReset();
    end else begin
      oldState = mState;
      editOk   = 1'b0;
      mLoad    = 1'b0;
      if (oldState == 0 && (btn_sel || btn_inc || btn_dec)) begin
        mBlinkCnt = 0;
        mPhase    = 1'b0;
      end else begin
        mBlinkCnt = mBlinkCnt + 1;
        if (mBlinkCnt == BLINK_DIV) begin
          mBlinkCnt = 0;
          mPhase    = !mPhase;
        end
      end
      case (oldState)
        0: begin
          if (btn_start && modelPreset() != 24'h0) begin
            mState = 1; mLoad = 1'b1; mRun = 1'b1;
          end else begin
            editOk = 1'b1;
          end
        end
        1: begin
          if (tmr_zero) begin
            mState = 0; mRun = 1'b0;
          end else if (btn_start) begin
            mState = 2; mRun = 1'b0;
          end
        end
        default: begin
          if (btn_start) begin
            mState = 1; mRun = 1'b1;
          end else if (btn_mode) begin
            mState = 0;
          end
        end
      endcase
      if (editOk) begin
        if (btn_inc && !btn_dec) mDig[mSel] = (mDig[mSel] + 1) % (digitMax(mSel) + 1);
        if (btn_dec && !btn_inc) mDig[mSel] = (mDig[mSel] + digitMax(mSel)) % (digitMax(mSel) + 1);
        if (btn_sel) mSel = (mSel + 1) % 6;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("model.preset", preset, modelPreset());
      checkOutput("model.load", 24'(load), 24'(mLoad));
      checkOutput("model.run_en", 24'(run_en), 24'(mRun));
      checkOutput("model.edit_sel", 24'(edit_sel), 24'(mSel));
      checkOutput("model.blank", 24'(blank), 24'(modelBlank()));
      checkOutput("model.state", 24'(state), 24'(mState));
    end
  end

  task automatic applyStimulus(input bit sel, input bit inc, input bit dec, input bit start,
                               input bit mode, input bit zero, input bit rst);
    btn_sel   = sel;
    btn_inc   = inc;
    btn_dec   = dec;
    btn_start = start;
    btn_mode  = mode;
    tmr_zero  = zero;
    RST       = rst;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge CLK);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkEn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("reset.preset", preset, 24'h010000);
    checkOutput("reset.load", 24'(load), 24'h0);
    checkOutput("reset.run_en", 24'(run_en), 24'h0);
    checkOutput("reset.edit_sel", 24'(edit_sel), 24'h0);
    checkOutput("reset.blank", 24'(blank), 24'h0);
    checkOutput("reset.state", 24'(state), 24'h0);

    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("inc3.preset", preset, 24'h010003);
    checkOutput("inc3.edit_sel", 24'(edit_sel), 24'h0);
    checkOutput("inc3.state", 24'(state), 24'h0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("dec_d1.preset", preset, 24'h010053);
    checkOutput("dec_d1.edit_sel", 24'(edit_sel), 24'h1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("sel_wrap.edit_sel", 24'(edit_sel), 24'h0);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("cleared.preset", preset, 24'h000000);
    checkOutput("cleared.edit_sel", 24'(edit_sel), 24'h0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("start_zero.load", 24'(load), 24'h0);
    checkOutput("start_zero.state", 24'(state), 24'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("start.load", 24'(load), 24'h1);
    checkOutput("start.run_en", 24'(run_en), 24'h1);
    checkOutput("start.state", 24'(state), 24'h1);
    idle(1);
    checkOutput("start_next.load", 24'(load), 24'h0);
    checkOutput("start_next.run_en", 24'(run_en), 24'h1);

    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("pause.state", 24'(state), 24'h2);
    checkOutput("pause.run_en", 24'(run_en), 24'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("pause_inc.preset", preset, 24'h000001);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkOutput("resume.state", 24'(state), 24'h1);
    checkOutput("resume.load", 24'(load), 24'h0);
    checkOutput("resume.run_en", 24'(run_en), 24'h1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("zero.run_en", 24'(run_en), 24'h0);
    checkOutput("zero.state", 24'(state), 24'h0);
    checkOutput("zero.preset", preset, 24'h000001);

    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("blink_clr.blank", 24'(blank), 24'h0);
    idle(3);
    checkOutput("blink_3.blank", 24'(blank), 24'h0);
    idle(1);
`ifdef TIMER_PRESET_BLINK_EN
    checkOutput("blink_4.blank", 24'(blank), 24'h01);
`else
    checkOutput("blink_4.blank", 24'(blank), 24'h00);
`endif
    idle(4);
    checkOutput("blink_8.blank", 24'(blank), 24'h0);

    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("run2.state", 24'(state), 24'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst_run.preset", preset, 24'h010000);
    checkOutput("rst_run.run_en", 24'(run_en), 24'h0);
    checkOutput("rst_run.state", 24'(state), 24'h0);
    checkOutput("rst_run.load", 24'(load), 24'h0);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 299) == 0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
